i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_tx.sv | 151 +++++++++++++++
 tb/tb_i2s_tx.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// i2s_tx: stereo I2S transmitter (MSB first, word select leads MSB by one bclk)
// with a one-frame pending buffer in front of the left/right shift registers.
// Define I2S_TX_UNDERRUN_EN to add the o_underrun pulse output.
module i2s_tx #(
    parameter int unsigned size     = 16,
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid,
    input  logic [size-1:0] i_left,
    input  logic [size-1:0] i_right,
    output logic            o_ready,
    output logic            o_bclk,
    output logic            o_lrck,
    output logic            o_sdata
`ifdef I2S_TX_UNDERRUN_EN
    ,
    output logic            o_underrun
`endif
);

    localparam int unsigned FRAME_BITS = 2 * size;
    localparam int unsigned KW         = $clog2(FRAME_BITS);
    localparam int unsigned DW         = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [KW-1:0] K_LAST   = KW'(FRAME_BITS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

    logic [DW-1:0]   div_cnt;
    logic [KW-1:0]   k;
    logic [size-1:0] shift_l;
    logic [size-1:0] shift_r;
    logic [size-1:0] pend_l;
    logic [size-1:0] pend_r;

    logic            div_wrap_c;
    logic            fall_c;
    logic            frame_start_c;
    logic            load_c;
    logic            accept_c;
    logic [KW-1:0]   k_next_c;
    logic [KW-1:0]   shamt_c;
    logic [size-1:0] word_l_c;
    logic [size-1:0] word_r_c;
    logic [size-1:0] bit_word_c;
    logic            sdata_c;
    logic            lrck_c;

    // Next-slot decode: falling-event detect, frame-start load and the bit for the new slot
    always_comb begin
        div_wrap_c    = 1'b0;
        fall_c        = 1'b0;
        frame_start_c = 1'b0;
        load_c        = 1'b0;
        accept_c      = 1'b0;
        k_next_c      = '0;
        shamt_c       = '0;
        word_l_c      = shift_l;
        word_r_c      = shift_r;
        bit_word_c    = '0;
        sdata_c       = 1'b0;
        lrck_c        = 1'b0;

        div_wrap_c    = (div_cnt == DIV_LAST);
        fall_c        = div_wrap_c && o_bclk;
        k_next_c      = (k == K_LAST) ? '0 : k + KW'(1);
        frame_start_c = fall_c && (k == K_LAST);
        load_c        = frame_start_c && !o_ready;
        accept_c      = valid && o_ready;

        // Slot 0 must already see the freshly loaded frame
        if (load_c) begin
            word_l_c = pend_l;
            word_r_c = pend_r;
        end

        if (k_next_c < KW'(size)) begin
            shamt_c    = KW'(size - 1) - k_next_c;
            bit_word_c = word_l_c >> shamt_c;
        end else begin
            shamt_c    = K_LAST - k_next_c;
            bit_word_c = word_r_c >> shamt_c;
        end
        sdata_c = bit_word_c[0];
        lrck_c  = (k_next_c >= KW'(size - 1)) && (k_next_c <= KW'(FRAME_BITS - 2));
    end

    // Bit clock divider: o_bclk toggles every BCLK_DIV clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            o_bclk  <= 1'b0;
        end else begin
            div_cnt <= div_wrap_c ? '0 : div_cnt + DW'(1);
            if (div_wrap_c) begin
                o_bclk <= ~o_bclk;
            end
        end
    end

    // Slot counter and serial outputs, updated only on bclk falling events
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k       <= K_LAST;
            o_sdata <= 1'b0;
            o_lrck  <= 1'b0;
        end else if (fall_c) begin
            k       <= k_next_c;
            o_sdata <= sdata_c;
            o_lrck  <= lrck_c;
        end
    end

    // Frame registers: reload from pending at frame start, otherwise hold (underrun repeats)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_l <= '0;
            shift_r <= '0;
        end else if (load_c) begin
            shift_l <= pend_l;
            shift_r <= pend_r;
        end
    end

    // Pending buffer; o_ready is the registered "pending empty" flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_l  <= '0;
            pend_r  <= '0;
            o_ready <= 1'b1;
        end else if (accept_c) begin
            pend_l  <= i_left;
            pend_r  <= i_right;
            o_ready <= 1'b0;
        end else if (load_c) begin
            o_ready <= 1'b1;
        end
    end

`ifdef I2S_TX_UNDERRUN_EN
    // One-clk pulse when a frame starts with nothing pending
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_underrun <= 1'b0;
        end else begin
            o_underrun <= frame_start_c && o_ready;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scenario tasks plus a randomized run against a frame-level I2S model.
module tb_i2s_tx;

    localparam int unsigned SIZE      = 16;
    localparam int unsigned DIV       = 2;
    localparam int unsigned SLOTS     = 2 * SIZE;
    localparam int unsigned BCLK_P    = 2 * DIV;
    localparam int unsigned FRAME_CLK = SLOTS * BCLK_P;
    localparam logic [SLOTS-1:0] LRCK_PAT = 32'h7FFF_8000;

    logic            clk     = 1'b0;
    logic            rst     = 1'b1;
    logic            valid   = 1'b0;
    logic [SIZE-1:0] i_left  = '0;
    logic [SIZE-1:0] i_right = '0;
    logic            o_ready;
    logic            o_bclk;
    logic            o_lrck;
    logic            o_sdata;
`ifdef I2S_TX_UNDERRUN_EN
    logic            o_underrun;
`endif

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    i2s_tx #(.size(SIZE), .BCLK_DIV(DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .i_left  (i_left),
        .i_right (i_right),
        .o_ready (o_ready),
        .o_bclk  (o_bclk),
        .o_lrck  (o_lrck),
        .o_sdata (o_sdata)
`ifdef I2S_TX_UNDERRUN_EN
        ,
        .o_underrun (o_underrun)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: clk edges since reset release, pending slot and frame now playing
    int unsigned     cyc;
    logic            m_full;
    logic [SIZE-1:0] m_pl, m_pr, m_cl, m_cr;
`ifdef I2S_TX_UNDERRUN_EN
    logic            m_urun;
`endif
    logic            exp_ready, exp_bclk, exp_lrck, exp_sdata;

    // Frame monitor: reassembles words and word-select pattern from the serial stream
    int unsigned     obs_slot = SLOTS - 1;
    logic            obs_prev = 1'b0;
    logic [SIZE-1:0] obs_l = '0, obs_r = '0;
    logic [SLOTS-1:0] obs_lr = '0;
    logic [SIZE-1:0] q_l[$];
    logic [SIZE-1:0] q_r[$];
    logic [SLOTS-1:0] q_lr[$];

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            obs_slot = SLOTS - 1;
            obs_prev = 1'b0;
        end else begin
            if (obs_prev && !o_bclk) begin
                obs_slot = (obs_slot + 1) % SLOTS;
                if (obs_slot < SIZE) obs_l = {obs_l[SIZE-2:0], o_sdata};
                else                 obs_r = {obs_r[SIZE-2:0], o_sdata};
                obs_lr = {o_lrck, obs_lr[SLOTS-1:1]};
                if (obs_slot == SLOTS - 1) begin
                    q_l.push_back(obs_l);
                    q_r.push_back(obs_r);
                    q_lr.push_back(obs_lr);
                end
            end
            obs_prev = o_bclk;
        end
    end

    task automatic model_reset();
        cyc = 0; m_full = 1'b0;
        m_pl = '0; m_pr = '0; m_cl = '0; m_cr = '0;
`ifdef I2S_TX_UNDERRUN_EN
        m_urun = 1'b0;
`endif
        exp_ready = 1'b1; exp_bclk = 1'b0; exp_lrck = 1'b0; exp_sdata = 1'b0;
    endtask

    // Drive one clk cycle and advance the model; returns 1 time unit after the edge
    task automatic step(input logic v, input logic [SIZE-1:0] l, input logic [SIZE-1:0] r);
        logic acc, load;
        int unsigned n, s;
        logic [SIZE-1:0] t;
        valid = v; i_left = l; i_right = r;
        acc = v && !m_full;
        @(posedge clk);
        cyc++;
        n = cyc / BCLK_P;
        load = 1'b0;
`ifdef I2S_TX_UNDERRUN_EN
        m_urun = 1'b0;
`endif
        if ((cyc % BCLK_P) == 0 && ((n - 1) % SLOTS) == 0) begin
            if (m_full) begin
                m_cl = m_pl; m_cr = m_pr; load = 1'b1;
            end else begin
`ifdef I2S_TX_UNDERRUN_EN
                m_urun = 1'b1;
`endif
            end
        end
        if (acc) begin
            m_pl = l; m_pr = r; m_full = 1'b1;
        end else if (load) begin
            m_full = 1'b0;
        end
        exp_ready = !m_full;
        exp_bclk  = ((cyc / DIV) % 2) == 1;
        if (n == 0) begin
            exp_lrck = 1'b0; exp_sdata = 1'b0;
        end else begin
            s = (n - 1) % SLOTS;
            exp_lrck = (s >= SIZE - 1) && (s <= SLOTS - 2);
            t = (s < SIZE) ? (m_cl >> (SIZE - 1 - s)) : (m_cr >> (SLOTS - 1 - s));
            exp_sdata = t[0];
        end
        #1;
    endtask

    task automatic run_to(input int unsigned target);
        while (cyc < target) step(1'b0, '0, '0);
    endtask

    task automatic do_reset();
        valid = 1'b0; i_left = '0; i_right = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        q_l.delete(); q_r.delete(); q_lr.delete();
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        valid = 1'b1; i_left = 16'hFFFF; i_right = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        vectors++; if (o_bclk !== 1'b0) begin miscompares++; $display("FAIL reset_bclk got=%b exp=0", o_bclk); end
        vectors++; if (o_lrck !== 1'b0) begin miscompares++; $display("FAIL reset_lrck got=%b exp=0", o_lrck); end
        vectors++; if (o_sdata !== 1'b0) begin miscompares++; $display("FAIL reset_sdata got=%b exp=0", o_sdata); end
`ifdef I2S_TX_UNDERRUN_EN
        vectors++; if (o_underrun !== 1'b0) begin miscompares++; $display("FAIL reset_underrun got=%b exp=0", o_underrun); end
`endif
        valid = 1'b0;
    endtask

    task automatic test_basic();
        logic prev;
        int unsigned last_t, n_tog, nfall, f0, f32;
        do_reset();
        step(1'b1, 16'hA5C3, 16'h0F01);
        vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL basic_accept_ready got=%b exp=0", o_ready); end
        prev = o_bclk; last_t = 0; n_tog = 0; nfall = 0; f0 = 0; f32 = 0;
        while (cyc < FRAME_CLK + BCLK_P) begin
            step(1'b0, '0, '0);
            if (o_bclk !== prev) begin
                vectors++;
                if (cyc - last_t != DIV) begin
                    miscompares++; $display("FAIL bclk_half_period got=%0d exp=%0d at cyc %0d", cyc - last_t, DIV, cyc);
                end
                if (prev === 1'b1) begin
                    if (nfall == 0) f0 = cyc;
                    if (nfall == SLOTS) f32 = cyc;
                    nfall++;
                end
                n_tog++; last_t = cyc; prev = o_bclk;
            end
        end
        vectors++; if (n_tog != (FRAME_CLK + BCLK_P) / DIV) begin miscompares++; $display("FAIL bclk_toggles got=%0d exp=%0d", n_tog, (FRAME_CLK + BCLK_P) / DIV); end
        vectors++; if (f0 != BCLK_P) begin miscompares++; $display("FAIL first_fall got=%0d exp=%0d", f0, BCLK_P); end
        vectors++; if (f32 - f0 != FRAME_CLK) begin miscompares++; $display("FAIL frame_length got=%0d exp=%0d", f32 - f0, FRAME_CLK); end
        vectors++;
        if (q_l.size() != 1) begin
            miscompares++; $display("FAIL basic_frames got=%0d exp=1", q_l.size());
        end else begin
            vectors++; if (q_l[0] !== 16'hA5C3) begin miscompares++; $display("FAIL basic_left got=%h exp=a5c3", q_l[0]); end
            vectors++; if (q_r[0] !== 16'h0F01) begin miscompares++; $display("FAIL basic_right got=%h exp=0f01", q_r[0]); end
            vectors++; if (q_lr[0] !== LRCK_PAT) begin miscompares++; $display("FAIL basic_lrck got=%h exp=%h", q_lr[0], LRCK_PAT); end
        end
    endtask

    task automatic test_drop();
        do_reset();
        step(1'b1, 16'h1234, 16'h5678);
        step(1'b1, 16'hDEAD, 16'hBEEF);
        step(1'b1, 16'hDEAD, 16'hBEEF);
        vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL drop_ready_busy got=%b exp=0", o_ready); end
        step(1'b0, '0, '0);
        vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL drop_ready_after_load got=%b exp=1", o_ready); end
        run_to(2 * FRAME_CLK + BCLK_P - 1);
        vectors++;
        if (q_l.size() != 2) begin
            miscompares++; $display("FAIL drop_frames got=%0d exp=2", q_l.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (q_l[i] !== 16'h1234 || q_r[i] !== 16'h5678) begin
                    miscompares++; $display("FAIL drop_frame%0d got=%h/%h exp=1234/5678", i, q_l[i], q_r[i]);
                end
            end
        end
    endtask

    task automatic test_underrun();
`ifdef I2S_TX_UNDERRUN_EN
        int unsigned urun_n;
        urun_n = 0;
`endif
        do_reset();
        step(1'b1, 16'hA5C3, 16'h0F01);
        while (cyc < 2 * FRAME_CLK + BCLK_P - 1) begin
            step(1'b0, '0, '0);
`ifdef I2S_TX_UNDERRUN_EN
            if (o_underrun === 1'b1) urun_n++;
`endif
        end
        vectors++;
        if (q_l.size() != 2) begin
            miscompares++; $display("FAIL underrun_frames got=%0d exp=2", q_l.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (q_l[i] !== 16'hA5C3 || q_r[i] !== 16'h0F01 || q_lr[i] !== LRCK_PAT) begin
                    miscompares++; $display("FAIL underrun_repeat%0d got=%h/%h/%h exp=a5c3/0f01/%h", i, q_l[i], q_r[i], q_lr[i], LRCK_PAT);
                end
            end
        end
`ifdef I2S_TX_UNDERRUN_EN
        vectors++; if (urun_n != 1) begin miscompares++; $display("FAIL underrun_pulses got=%0d exp=1", urun_n); end
`endif
    endtask

    task automatic test_accept_underrun();
        logic exp_r;
        do_reset();
        step(1'b1, 16'hA5C3, 16'h0F01);
        run_to(FRAME_CLK + BCLK_P - 1);
        step(1'b1, 16'h1357, 16'h2468);
        vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL acc_urun_ready got=%b exp=0", o_ready); end
`ifdef I2S_TX_UNDERRUN_EN
        vectors++; if (o_underrun !== 1'b1) begin miscompares++; $display("FAIL acc_urun_pulse got=%b exp=1", o_underrun); end
`endif
        while (cyc < 2 * FRAME_CLK + BCLK_P) begin
            step(1'b0, '0, '0);
            exp_r = (cyc >= 2 * FRAME_CLK + BCLK_P);
            vectors++;
            if (o_ready !== exp_r) begin
                miscompares++; $display("FAIL acc_urun_ready_hold got=%b exp=%b at cyc %0d", o_ready, exp_r, cyc);
            end
        end
        run_to(3 * FRAME_CLK + BCLK_P - 1);
        vectors++;
        if (q_l.size() != 3) begin
            miscompares++; $display("FAIL acc_urun_frames got=%0d exp=3", q_l.size());
        end else begin
            vectors++; if (q_l[0] !== 16'hA5C3 || q_r[0] !== 16'h0F01) begin miscompares++; $display("FAIL acc_urun_f0 got=%h/%h exp=a5c3/0f01", q_l[0], q_r[0]); end
            vectors++; if (q_l[1] !== 16'hA5C3 || q_r[1] !== 16'h0F01) begin miscompares++; $display("FAIL acc_urun_f1 got=%h/%h exp=a5c3/0f01", q_l[1], q_r[1]); end
            vectors++; if (q_l[2] !== 16'h1357 || q_r[2] !== 16'h2468) begin miscompares++; $display("FAIL acc_urun_f2 got=%h/%h exp=1357/2468", q_l[2], q_r[2]); end
        end
    endtask

    task automatic test_reset_mid();
        logic prev;
        int unsigned first;
        do_reset();
        step(1'b1, 16'hA5C3, 16'h0F01);
        run_to(32);
        step(1'b1, 16'h1111, 16'h2222);
        step(1'b0, '0, '0);
        vectors++; if (o_sdata !== 1'b1 || o_bclk !== 1'b1) begin miscompares++; $display("FAIL mid_slot7 got=%b/%b exp=1/1", o_sdata, o_bclk); end
        rst = 1'b0;
        #1;
        vectors++; if (o_bclk !== 1'b0) begin miscompares++; $display("FAIL mid_rst_bclk got=%b exp=0", o_bclk); end
        vectors++; if (o_lrck !== 1'b0) begin miscompares++; $display("FAIL mid_rst_lrck got=%b exp=0", o_lrck); end
        vectors++; if (o_sdata !== 1'b0) begin miscompares++; $display("FAIL mid_rst_sdata got=%b exp=0", o_sdata); end
        vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready got=%b exp=1", o_ready); end
        do_reset();
        prev = o_bclk; first = 0;
        for (int i = 1; i <= 2 * BCLK_P; i++) begin
            step(1'b0, '0, '0);
            if (first == 0 && prev === 1'b1 && o_bclk === 1'b0) first = i;
            prev = o_bclk;
        end
        vectors++; if (first != BCLK_P) begin miscompares++; $display("FAIL mid_first_fall got=%0d exp=%0d", first, BCLK_P); end
        run_to(FRAME_CLK + BCLK_P - 1);
        vectors++;
        if (q_l.size() != 1) begin
            miscompares++; $display("FAIL mid_frames got=%0d exp=1", q_l.size());
        end else begin
            vectors++; if (q_l[0] !== 16'h0000 || q_r[0] !== 16'h0000) begin miscompares++; $display("FAIL mid_abort_frame got=%h/%h exp=0000/0000", q_l[0], q_r[0]); end
        end
    endtask

    task automatic test_random();
        logic v;
        int unsigned thr;
        do_reset();
        for (int i = 0; i < 2400; i++) begin
            thr = (i < 800) ? 2 : ((i < 1600) ? 10 : 50);
            v = ($urandom_range(99) < thr);
            step(v, SIZE'($urandom), SIZE'($urandom));
            vectors++; if (o_ready !== exp_ready) begin miscompares++; $display("FAIL rnd_ready got=%b exp=%b cyc %0d", o_ready, exp_ready, cyc); end
            vectors++; if (o_bclk !== exp_bclk) begin miscompares++; $display("FAIL rnd_bclk got=%b exp=%b cyc %0d", o_bclk, exp_bclk, cyc); end
            vectors++; if (o_lrck !== exp_lrck) begin miscompares++; $display("FAIL rnd_lrck got=%b exp=%b cyc %0d", o_lrck, exp_lrck, cyc); end
            vectors++; if (o_sdata !== exp_sdata) begin miscompares++; $display("FAIL rnd_sdata got=%b exp=%b cyc %0d", o_sdata, exp_sdata, cyc); end
`ifdef I2S_TX_UNDERRUN_EN
            vectors++; if (o_underrun !== m_urun) begin miscompares++; $display("FAIL rnd_underrun got=%b exp=%b cyc %0d", o_underrun, m_urun, cyc); end
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_drop();
        test_underrun();
        test_accept_underrun();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
